// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the parametrised rate-1/2
//               convolutional encoder. Holds the FSM state type, the symbol
//               width, the legacy generator polynomials, the tail-length rule
//               and the tap-parity helper.
//               Configuration macro: TAIL_FLUSH_EN (adds K-1 zero tail bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int SYM_W = 2;

    // Legacy K=3 generators; bit K-1 taps the current input, bit 0 the oldest bit.
    localparam logic [2:0] DEF_G0 = 3'b111;
    localparam logic [2:0] DEF_G1 = 3'b101;

`ifdef TAIL_FLUSH_EN
    localparam bit c_TAIL_FLUSH = 1'b1;
`else
    localparam bit c_TAIL_FLUSH = 1'b0;
`endif

    // Number of zero tail bits appended to every frame.
    function automatic int tail_len(input int k);
        return c_TAIL_FLUSH ? (k - 1) : 0;
    endfunction

    // Modulo-2 sum of the input bits selected by a generator polynomial.
    function automatic logic tap_parity(input logic [31:0] taps, input logic [31:0] vec);
        return ^(taps & vec);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_sym_gen.sv
// ============================================================================
// Module      : conv_sym_gen
// Description : Combinational symbol generator. Forms {u, sr} and produces
//               the two generator parities as one 2-bit symbol {g1,g0}.
// Ports       : u   - current input bit
//               sr  - K-1 past bits, sr[K-2] newest, sr[0] oldest
//               sym - encoded symbol {g1,g0}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sym_gen
    import conv_pkg::*;
#(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = K'(DEF_G0),
    parameter logic [K-1:0] G1 = K'(DEF_G1)
) (
    input  logic             u,
    input  logic [K-2:0]     sr,
    output logic [SYM_W-1:0] sym
);

    logic [K-1:0] w_taps_in;

    // Bit ordering matches the generator polynomials: MSB is the current input.
    assign w_taps_in = {u, sr};

    assign sym = {tap_parity(32'(G1), 32'(w_taps_in)),
                  tap_parity(32'(G0), 32'(w_taps_in))};

endmodule

`default_nettype wire

// File: rtl/conv_encoder_param.sv
// ============================================================================
// Module      : conv_encoder_param
// Description : Parametrised rate-1/2 feed-forward convolutional encoder.
//               Captures a MSG_LEN-bit message on start, encodes it LSB
//               first, streams 2-bit symbols over valid/ready and builds
//               the full codeword in parallel.
//               Configuration macro: TAIL_FLUSH_EN - when defined, K-1 zero
//               tail bits terminate the trellis in state 0.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous, active-low reset
//               start     - frame request, accepted only in IDLE
//               m_text_in - message, sampled on the accepted start cycle
//               sym_valid - encoded symbol available
//               sym_ready - downstream accepts the symbol
//               sym_data  - {g1,g0} of the current symbol
//               code_out  - codeword, symbol i at [2*i +: 2]
//               busy      - high outside IDLE
//               done      - one-cycle frame-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder_param
    import conv_pkg::*;
#(
    parameter int           MSG_LEN = 8,
    parameter int           K       = 3,
    parameter logic [K-1:0] G0      = K'(DEF_G0),
    parameter logic [K-1:0] G1      = K'(DEF_G1),
    localparam int          NSYM    = MSG_LEN + tail_len(K),
    localparam int          CODE_W  = SYM_W * NSYM
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MSG_LEN-1:0] m_text_in,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic [SYM_W-1:0]   sym_data,
    output logic [CODE_W-1:0]  code_out,
    output logic               busy,
    output logic               done
);

    localparam int                 c_IDX_W    = $clog2(NSYM + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NSYM - 1);

    state_t             r_state;
    logic [MSG_LEN-1:0] r_msg;
    logic [c_IDX_W-1:0] r_idx;
    logic [K-2:0]       r_sr;
    logic [CODE_W-1:0]  r_code;

    logic               w_u;
    logic               w_fire;
    logic [K-2:0]       w_sr_next;
    logic [SYM_W-1:0]   w_sym;

    // Message bit at the current index; once idx passes MSG_LEN the shifted
    // mask falls off the top and the tail input reads as zero.
    assign w_u    = |(r_msg & (MSG_LEN'(1) << r_idx));
    assign w_fire = (r_state == ENCODE) && sym_ready;

    // New bit enters at the newest end (sr[K-2]); the oldest drops out.
    generate
        if (K == 2) begin : g_sr_single
            assign w_sr_next = w_u;
        end else begin : g_sr_multi
            assign w_sr_next = {w_u, r_sr[K-2:1]};
        end
    endgenerate

    conv_sym_gen #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_sym_gen (
        .u   (w_u),
        .sr  (r_sr),
        .sym (w_sym)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_msg   <= '0;
            r_idx   <= '0;
            r_sr    <= '0;
            r_code  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_msg   <= m_text_in;
                        r_sr    <= '0;
                        r_idx   <= '0;
                        r_code  <= '0;
                        r_state <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (w_fire) begin
                        r_code[SYM_W*r_idx +: SYM_W] <= w_sym;
                        r_sr  <= w_sr_next;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only, so sym_data cannot move while
    // the stream is stalled.
    assign sym_valid = (r_state == ENCODE);
    assign sym_data  = (r_state == ENCODE) ? w_sym : '0;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign code_out  = r_code;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_param.sv
// ============================================================================
// Module      : tb_conv_encoder_param
// Description : Self-checking bench for conv_encoder_param. Table-driven
//               frames with known codewords, hand-written stall / busy-start
//               / mid-frame reset sequences, and random frames with random
//               backpressure checked against a bit-level trellis model.
//               Honours TAIL_FLUSH_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_encoder_param;

    localparam int           MSG_LEN = 8;
    localparam int           K       = 3;
    localparam logic [K-1:0] G0      = 3'b111;
    localparam logic [K-1:0] G1      = 3'b101;
`ifdef TAIL_FLUSH_EN
    localparam int TAIL = K - 1;
`else
    localparam int TAIL = 0;
`endif
    localparam int NSYM = MSG_LEN + TAIL;
    localparam int CW   = 2 * NSYM;

    logic               clk       = 1'b0;
    logic               reset     = 1'b0;
    logic               start     = 1'b0;
    logic               sym_ready = 1'b0;
    logic [MSG_LEN-1:0] m_text_in = '0;
    logic               sym_valid;
    logic               busy;
    logic               done;
    logic [1:0]         sym_data;
    logic [CW-1:0]      code_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model results for the frame in flight.
    logic [1:0]    m_sym [NSYM];
    logic [CW-1:0] m_code;

    typedef struct {
        logic [MSG_LEN-1:0] msg;
        logic [CW-1:0]      code;
    } vec_t;

    vec_t tbl [3];

    always #5 clk = ~clk;

    conv_encoder_param dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .m_text_in (m_text_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_data  (sym_data),
        .code_out  (code_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Trellis model: input sequence u[0..NSYM-1] (message then zero tail);
    // generator bit b weights u[i-(K-1-b)], with u of negative time = 0.
    function automatic void model(input logic [MSG_LEN-1:0] msg);
        int ub [NSYM];
        for (int i = 0; i < NSYM; i++) ub[i] = (i < MSG_LEN) ? int'(msg[i]) : 0;
        m_code = '0;
        for (int i = 0; i < NSYM; i++) begin
            int p0 = 0;
            int p1 = 0;
            for (int b = 0; b < K; b++) begin
                int j  = i - (K - 1 - b);
                int ib = (j >= 0) ? ub[j] : 0;
                if (G0[b]) p0 = p0 ^ ib;
                if (G1[b]) p1 = p1 ^ ib;
            end
            m_sym[i] = {p1[0], p0[0]};
            m_code[2*i +: 2] = m_sym[i];
        end
    endfunction

    // mode 0: ready held high, 1: random ready, 2: 3-cycle stall at idx 2,
    // 3: reset asserted at idx 4 (frame aborted, task returns early).
    task automatic run_frame(input logic [MSG_LEN-1:0] msg, input int mode,
                             input logic [CW-1:0] exp_code);
        int idx    = 0;
        int cyc    = 0;
        int stall  = 0;
        bit pulsed = 1'b0;
        @(negedge clk);
        chk("idle_before_start", busy, 1'b0);
        start     = 1'b1;
        m_text_in = msg;
        sym_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        m_text_in = ~msg;
        cyc       = 1;
        while (idx < NSYM && cyc < 400) begin
            if (pulsed) start = 1'b0;
            chk("sym_valid", sym_valid, 1'b1);
            chk("busy_in_frame", busy, 1'b1);
            chk("done_early", done, 1'b0);
            chk($sformatf("sym_data[%0d]", idx), sym_data, m_sym[idx]);
            if (mode == 3 && idx == 4) begin
                reset = 1'b0;
                start = 1'b0;
                #1;
                chk("rst_sym_valid", sym_valid, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_sym_data", sym_data, 2'b00);
                chk("rst_code_out", code_out, '0);
                @(negedge clk);
                chk("rst_no_done", done, 1'b0);
                reset     = 1'b1;
                sym_ready = 1'b0;
                return;
            end
            if (mode == 2 && idx == 2) chk("stall_hold_sym", sym_data, 2'b01);
            // A start pulse mid-frame must be ignored.
            if (idx == 3 && !pulsed) begin
                start     = 1'b1;
                m_text_in = MSG_LEN'($urandom);
                pulsed    = 1'b1;
            end
            case (mode)
                1:       sym_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (idx == 2 && stall < 3) begin
                        sym_ready = 1'b0;
                        stall++;
                    end else begin
                        sym_ready = 1'b1;
                    end
                end
                default: sym_ready = 1'b1;
            endcase
            if (sym_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("symbol_count", idx, NSYM);
        chk("done_pulse", done, 1'b1);
        chk("done_valid_low", sym_valid, 1'b0);
        chk("done_busy", busy, 1'b1);
        if (mode == 0) chk("done_cycle", cyc, NSYM + 1);
        sym_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("code_out", code_out, exp_code);
        @(negedge clk);
        chk("code_hold", code_out, exp_code);
    endtask

    initial begin
`ifdef TAIL_FLUSH_EN
        tbl[0] = '{msg: 8'h01, code: 20'h00037};
        tbl[1] = '{msg: 8'hFF, code: 20'hE555B};
        tbl[2] = '{msg: 8'h00, code: 20'h00000};
`else
        tbl[0] = '{msg: 8'h01, code: 16'h0037};
        tbl[1] = '{msg: 8'hFF, code: 16'h555B};
        tbl[2] = '{msg: 8'h00, code: 16'h0000};
`endif

        reset = 1'b0;
        #12;
        chk("reset_sym_valid", sym_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_code_out", code_out, '0);
        chk("reset_sym_data", sym_data, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            model(tbl[i].msg);
            run_frame(tbl[i].msg, 0, tbl[i].code);
        end

        // Backpressure at idx 2 on the all-ones message.
        model(tbl[1].msg);
        run_frame(tbl[1].msg, 2, tbl[1].code);

        // Reset mid-frame, then a clean frame.
        model(8'hFF);
        run_frame(8'hFF, 3, '0);
        model(tbl[0].msg);
        run_frame(tbl[0].msg, 0, tbl[0].code);

        for (int n = 0; n < 8; n++) begin
            logic [MSG_LEN-1:0] msg;
            msg = MSG_LEN'($urandom);
            model(msg);
            run_frame(msg, 1, m_code);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
